// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT note scheduler.
// Contents:
//   - state_t: scheduler FSM states (IDLE, SCAN, DECIDE).
//   - Default widths IDW, MAGW and CNTW.
//   - Default loudness threshold THRESHOLD and hold time L_TIME.
package fft_ctrl_pkg;

    localparam int IDW       = 8;
    localparam int MAGW      = 5;
    localparam int CNTW      = 20;
    localparam int THRESHOLD = 8;
    localparam int L_TIME    = 75000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2
    } state_t;

endpackage

// File: rtl/fft_peak_tracker.sv
// Running peak search over one frame of bin magnitudes.
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   clear                restart the search (peak and index go to 0)
//   smp_en               smp_data/smp_idx hold a valid bin this cycle
//   smp_idx, smp_data    bin index and magnitude being offered
//   peak_idx, peak_magn  best bin seen since the last clear
module fft_peak_tracker #(
    parameter int IDW     = fft_ctrl_pkg::IDW,
    parameter int MAGW    = fft_ctrl_pkg::MAGW,
    parameter int MIN_BIN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            smp_en,
    input  logic [IDW-1:0]  smp_idx,
    input  logic [MAGW-1:0] smp_data,
    output logic [IDW-1:0]  peak_idx,
    output logic [MAGW-1:0] peak_magn
);

    localparam logic [IDW-1:0] MIN_IDX = IDW'(MIN_BIN);

    // Strict greater-than: on a tie the earlier (lower) bin is kept.
    // Bins below MIN_IDX (DC) are read but never compete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_idx  <= '0;
            peak_magn <= '0;
        end else if (clear) begin
            peak_idx  <= '0;
            peak_magn <= '0;
        end else if (smp_en && (smp_idx >= MIN_IDX) && (smp_data > peak_magn)) begin
            peak_idx  <= smp_idx;
            peak_magn <= smp_data;
        end
    end

endmodule

// File: rtl/fft_note_scheduler.sv
// Reads one FFT magnitude frame out of the bin buffer after each frame-complete
// pulse, picks the peak bin, and emits a note event when the peak is loud, has
// been the same bin for STABLE frames, and the post-event hold has expired.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   i_frame_start   frame complete pulse (accepted only in IDLE)
//   o_rd_en         bin buffer read strobe
//   o_rd_addr       bin address, holds last value after a scan
//   i_rd_data       bin magnitude, one cycle after o_rd_en
//   o_busy          scan or decision in progress
//   o_valid         one-cycle note event pulse
//   o_max_id        bin of the last emitted event
//   o_max_magn      magnitude of the last emitted event
//   o_overrun       one-cycle pulse: frame start arrived while busy
//
// state  | meaning
// IDLE   | waiting for i_frame_start
// SCAN   | issuing reads for bins 0..NBIN-1 and folding in returned data
// DECIDE | one cycle: loudness, stability and hold check, maybe emit
module fft_note_scheduler #(
    parameter int NBIN      = 256,
    parameter int IDW       = fft_ctrl_pkg::IDW,
    parameter int MAGW      = fft_ctrl_pkg::MAGW,
    parameter int MIN_BIN   = 1,
    parameter int THRESHOLD = fft_ctrl_pkg::THRESHOLD,
    parameter int STABLE    = 2,
    parameter int L_TIME    = fft_ctrl_pkg::L_TIME,
    parameter int CNTW      = fft_ctrl_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_frame_start,
    output logic            o_rd_en,
    output logic [IDW-1:0]  o_rd_addr,
    input  logic [MAGW-1:0] i_rd_data,
    output logic            o_busy,
    output logic            o_valid,
    output logic [IDW-1:0]  o_max_id,
    output logic [MAGW-1:0] o_max_magn,
    output logic            o_overrun
);
    import fft_ctrl_pkg::*;

    localparam int              SW         = $clog2(STABLE + 1);
    localparam logic [IDW-1:0]  LAST_ADDR  = IDW'(NBIN - 1);
    localparam logic [SW-1:0]   STABLE_MAX = SW'(STABLE);
    localparam logic [MAGW-1:0] THR        = MAGW'(THRESHOLD);
    localparam logic [CNTW-1:0] HOLD_LOAD  = CNTW'(L_TIME);

    state_t          state_q, state_d;
    logic            start_acc;
    logic            rd_en_q, smp_en_q;
    logic [IDW-1:0]  rd_addr_q, smp_idx_q;
    logic [IDW-1:0]  pk_idx;
    logic [MAGW-1:0] pk_magn;
    logic [IDW-1:0]  cand_q, cand_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic [CNTW-1:0] hold_q;
    logic            loud, emit;
    logic            valid_q, overrun_q;
    logic [IDW-1:0]  max_id_q;
    logic [MAGW-1:0] max_magn_q;

    fft_peak_tracker #(
        .IDW     (IDW),
        .MAGW    (MAGW),
        .MIN_BIN (MIN_BIN)
    ) u_peak (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc),
        .smp_en    (smp_en_q),
        .smp_idx   (smp_idx_q),
        .smp_data  (i_rd_data),
        .peak_idx  (pk_idx),
        .peak_magn (pk_magn)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        loud      = 1'b0;
        emit      = 1'b0;
        cand_d    = cand_q;
        stable_d  = stable_q;
        case (state_q)
            IDLE: begin
                if (i_frame_start) begin
                    start_acc = 1'b1;
                    state_d   = SCAN;
                end
            end
            // Reads have stopped and the last returned sample is being folded in.
            SCAN: begin
                if (!rd_en_q && smp_en_q) state_d = DECIDE;
            end
            DECIDE: begin
                state_d = IDLE;
                loud    = pk_magn > THR;
                if (loud && (pk_idx == cand_q)) begin
                    stable_d = (stable_q >= STABLE_MAX) ? STABLE_MAX : stable_q + 1'b1;
                end else if (loud) begin
                    cand_d   = pk_idx;
                    stable_d = SW'(1);
                end else begin
                    stable_d = '0;
                end
                emit = loud && (stable_d == STABLE_MAX) && (hold_q == '0);
            end
            default: state_d = IDLE;
        endcase
    end

    // Read address issue; the sample strobe is the read strobe one cycle late,
    // matching the buffer's one-cycle read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            smp_en_q  <= 1'b0;
            smp_idx_q <= '0;
        end else begin
            smp_en_q  <= rd_en_q;
            smp_idx_q <= rd_addr_q;
            if (start_acc) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= '0;
            end else if (rd_en_q) begin
                if (rd_addr_q == LAST_ADDR) rd_en_q   <= 1'b0;
                else                        rd_addr_q <= rd_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q     <= '0;
            stable_q   <= '0;
            hold_q     <= '0;
            valid_q    <= 1'b0;
            max_id_q   <= '0;
            max_magn_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            valid_q   <= emit;
            overrun_q <= i_frame_start && (state_q != IDLE);
            if (emit) begin
                hold_q     <= HOLD_LOAD;
                max_id_q   <= pk_idx;
                max_magn_q <= pk_magn;
            end else if (hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
            end
        end
    end

    assign o_rd_en    = rd_en_q;
    assign o_rd_addr  = rd_addr_q;
    assign o_busy     = (state_q != IDLE);
    assign o_valid    = valid_q;
    assign o_max_id   = max_id_q;
    assign o_max_magn = max_magn_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_fft_note_scheduler.sv
module tb_fft_note_scheduler;

    localparam int NBIN = 16;
    localparam int IDW  = 4;
    localparam int MAGW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_frame_start = 1'b0;
    logic            o_rd_en;
    logic [IDW-1:0]  o_rd_addr;
    logic [MAGW-1:0] i_rd_data;
    logic            o_busy;
    logic            o_valid;
    logic [IDW-1:0]  o_max_id;
    logic [MAGW-1:0] o_max_magn;
    logic            o_overrun;

    fft_note_scheduler #(
        .NBIN      (NBIN),
        .IDW       (IDW),
        .MAGW      (MAGW),
        .MIN_BIN   (1),
        .THRESHOLD (8),
        .STABLE    (2),
        .L_TIME    (100),
        .CNTW      (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_frame_start (i_frame_start),
        .o_rd_en       (o_rd_en),
        .o_rd_addr     (o_rd_addr),
        .i_rd_data     (i_rd_data),
        .o_busy        (o_busy),
        .o_valid       (o_valid),
        .o_max_id      (o_max_id),
        .o_max_magn    (o_max_magn),
        .o_overrun     (o_overrun)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval following the n-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bin buffer model: one-cycle read latency.
    logic [MAGW-1:0] mem [NBIN];
    always @(posedge clk) i_rd_data <= o_rd_en ? mem[o_rd_addr] : '0;

    int valid_cyc[$];
    int ovr_cyc[$];
    int rd_cyc[$];
    int rd_adr[$];

    always @(negedge clk) begin
        if (o_valid)   valid_cyc.push_back(cyc);
        if (o_overrun) ovr_cyc.push_back(cyc);
        if (o_rd_en) begin
            rd_cyc.push_back(cyc);
            rd_adr.push_back(int'(o_rd_addr));
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(output int t);
        t = cyc;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic clear_log();
        valid_cyc.delete();
        ovr_cyc.delete();
        rd_cyc.delete();
        rd_adr.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
        tick();
    endtask

    task automatic load_pat(input int bg, input int a, input int ma,
                            input int b, input int mb, input int dc);
        for (int i = 0; i < NBIN; i++) mem[i] = MAGW'(bg);
        if (a >= 0) mem[a] = MAGW'(ma);
        if (b >= 0) mem[b] = MAGW'(mb);
        mem[0] = MAGW'(dc);
    endtask

    task automatic check_seq(input string name, input int first, input int t0);
        int bad;
        bad = 0;
        for (int k = 0; k < NBIN && (first + k) < rd_cyc.size(); k++)
            if (rd_adr[first + k] != k || rd_cyc[first + k] != t0 + 1 + k) bad++;
        check(name, bad, 0);
    endtask

    typedef struct {
        int bg;
        int a;
        int ma;
        int b;
        int mb;
        int dc;
        int nfr;
        int exp_nv;
        int exp_id;
        int exp_mag;
    } vec_t;

    vec_t vt[8];
    int   st[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, ts, s, found;

        //        bg  a  ma   b  mb  dc nfr nv  id mag
        vt[0] = '{3,  5, 20, -1,  0,  3, 2, 1,  5, 20};
        vt[1] = '{0,  3, 12,  9, 12, 31, 2, 1,  3, 12};
        vt[2] = '{2,  6,  8, -1,  0,  2, 3, 0,  0,  0};
        vt[3] = '{2,  6,  9, -1,  0,  2, 2, 1,  6,  9};
        vt[4] = '{4, 15, 31, -1,  0,  4, 2, 1, 15, 31};
        vt[5] = '{0, -1,  0, -1,  0,  0, 2, 0,  0,  0};
        vt[6] = '{3, 10, 20, -1,  0,  3, 1, 0,  0,  0};
        vt[7] = '{1,  1, 17, -1,  0,  0, 2, 1,  1, 17};

        // Reset state.
        rst = 1'b0;
        ticks(3);
        check("rst_rd_en",    o_rd_en,    0);
        check("rst_rd_addr",  o_rd_addr,  0);
        check("rst_busy",     o_busy,     0);
        check("rst_valid",    o_valid,    0);
        check("rst_max_id",   o_max_id,   0);
        check("rst_max_magn", o_max_magn, 0);
        check("rst_overrun",  o_overrun,  0);
        rst = 1'b1;
        tick();

        // Establish an emitted event, then reset in the middle of a scan.
        load_pat(3, 5, 20, -1, 0, 3);
        pulse_start(t); ticks(39);
        pulse_start(t); ticks(39);
        check("pre_reset_id", o_max_id, 5);
        pulse_start(t);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            if (o_rd_en && o_rd_addr == 4'd7) found = 1;
            else tick();
        end
        check("reach_bin7", found, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rd_en",    o_rd_en,    0);
        check("mid_rst_rd_addr",  o_rd_addr,  0);
        check("mid_rst_busy",     o_busy,     0);
        check("mid_rst_max_id",   o_max_id,   0);
        check("mid_rst_max_magn", o_max_magn, 0);
        tick();
        rst = 1'b1;
        clear_log();
        ticks(25);
        check("mid_rst_no_event", valid_cyc.size(), 0);

        // Clean scan after reset release.
        clear_log();
        pulse_start(t);
        ticks(16);
        check("scan_end_rd_en",   o_rd_en,   0);
        check("scan_end_rd_addr", o_rd_addr, 15);
        check("scan_last_busy",   o_busy,    1);
        tick();
        check("decide_busy", o_busy, 1);
        tick();
        check("post_decide_busy", o_busy, 0);
        check("scan_rd_count", rd_cyc.size(), NBIN);
        check_seq("scan_rd_seq", 0, t);

        // Table-driven frame patterns.
        for (int v = 0; v < 8; v++) begin
            apply_reset();
            load_pat(vt[v].bg, vt[v].a, vt[v].ma, vt[v].b, vt[v].mb, vt[v].dc);
            clear_log();
            st.delete();
            for (int f = 0; f < vt[v].nfr; f++) begin
                pulse_start(t);
                st.push_back(t);
                ticks(39);
            end
            check($sformatf("v%0d_nvalid", v), valid_cyc.size(), vt[v].exp_nv);
            if (vt[v].exp_nv > 0 && valid_cyc.size() > 0 && st.size() > 1)
                check($sformatf("v%0d_valid_cycle", v), valid_cyc[0], st[1] + 19);
            check($sformatf("v%0d_max_id", v),   o_max_id,   vt[v].exp_id);
            check($sformatf("v%0d_max_magn", v), o_max_magn, vt[v].exp_mag);
            check($sformatf("v%0d_overrun", v),  ovr_cyc.size(), 0);
        end

        // Hold timer: frames every 20 cycles, same loud peak.
        apply_reset();
        load_pat(2, 4, 15, -1, 0, 2);
        clear_log();
        pulse_start(s); ticks(19);
        for (int k = 1; k < 8; k++) begin
            pulse_start(t); ticks(19);
        end
        ticks(30);
        check("hold_nvalid", valid_cyc.size(), 2);
        if (valid_cyc.size() >= 2) begin
            check("hold_first_cycle",  valid_cyc[0], s + 39);
            check("hold_second_cycle", valid_cyc[1], s + 159);
        end
        check("hold_max_id", o_max_id, 4);

        // Overrun: starts during SCAN and DECIDE are ignored; first IDLE cycle accepts.
        apply_reset();
        load_pat(1, 7, 25, -1, 0, 1);
        pulse_start(t); ticks(39);
        clear_log();
        pulse_start(ts);
        ticks(4);
        i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
        ticks(12);
        check("ovr_decide_busy", o_busy, 1);
        i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
        check("ovr_idle_busy", o_busy, 0);
        i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
        check("ovr_restart_busy", o_busy, 1);
        ticks(30);
        check("ovr_count", ovr_cyc.size(), 2);
        if (ovr_cyc.size() >= 2) begin
            check("ovr_first_cycle",  ovr_cyc[0], ts + 6);
            check("ovr_second_cycle", ovr_cyc[1], ts + 19);
        end
        check("ovr_nvalid", valid_cyc.size(), 1);
        if (valid_cyc.size() >= 1)
            check("ovr_valid_cycle", valid_cyc[0], ts + 19);
        check("ovr_rd_count", rd_cyc.size(), 2 * NBIN);
        check_seq("ovr_rd_seq", 0, ts);
        check_seq("ovr_restart_seq", NBIN, ts + 19);
        check("ovr_max_id",   o_max_id,   7);
        check("ovr_max_magn", o_max_magn, 25);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_note_scheduler.md
Name: fft_note_scheduler

Overview:
- Sequences readout of one FFT magnitude frame from the bin buffer once the FFT signals frame completion.
- Finds the peak bin, applies the loudness threshold and a stability check, and rate-limits note events with a hold timer.
- Sits between the FFT core/bin SRAM and the downstream note/tone logic.
- Issues a single-cycle valid with the accepted peak bin index.

Parameters:
NBIN, 256, bins per frame scanned (power of 2)
IDW, 8, bin index width, log2(NBIN)
MAGW, 5, magnitude width
MIN_BIN, 1, lowest bin considered (excludes DC); lower bins are read but ignored
THRESHOLD, 8, peak magnitude must be strictly greater to count as loud
STABLE, 2, consecutive loud frames with identical peak bin required before emitting
L_TIME, 75000, hold time in clk cycles after an emitted event
CNTW, 20, hold counter width, must hold L_TIME

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
i_frame_start  in  1  one-cycle pulse: FFT frame complete, bin buffer readable
o_rd_en  out  1  bin buffer read strobe
o_rd_addr  out  IDW  bin address
i_rd_data  in  MAGW  bin magnitude, valid exactly 1 cycle after o_rd_en
o_busy  out  1  high in SCAN and DECIDE
o_valid  out  1  one-cycle pulse: new note event
o_max_id  out  IDW  last emitted peak bin, stable between pulses
o_max_magn  out  MAGW  magnitude of last emitted peak
o_overrun  out  1  one-cycle pulse: i_frame_start while busy

Behaviour:
- Reset, async while rst=0: state IDLE; all outputs 0; peak, candidate, stable count and hold counter cleared. Reset mid-scan abandons the frame with no event.
- IDLE: i_frame_start=1 at edge T moves to SCAN and clears running max to 0 and index to 0.
- SCAN:
  - o_rd_en=1 with o_rd_addr=k during cycle T+1+k, k=0..NBIN-1.
  - Data for bin k is sampled at the end of cycle T+2+k.
  - Update the running max only when k>=MIN_BIN and data > current max (strict), so ties keep the lowest index.
  - After bin NBIN-1 is issued, o_rd_en=0 and o_rd_addr holds its last value.
  - The final sample completes at cycle T+NBIN+1, then the block moves to DECIDE.
- DECIDE (one cycle, T+NBIN+2):
  - loud = max > THRESHOLD.
  - If loud and index == candidate, then stable = min(stable+1, STABLE).
  - Else if loud, then candidate = index and stable = 1.
  - Else stable = 0 and the candidate is unchanged.
  - Emit when loud, stable reaches STABLE this cycle or is already STABLE, and the hold counter is 0.
  - On emit, register o_max_id/o_max_magn and pulse o_valid in cycle T+NBIN+3. Load the hold counter with L_TIME.
  - Always return to IDLE. The earliest next start is sampled in cycle T+NBIN+3.
- Sustained identical note: after the hold expires, the next qualifying frame emits again (retrigger every >=L_TIME cycles).
- Hold counter: decrements by 1 every cycle while nonzero, independent of state, saturates at 0. A load on emit overrides the decrement.
- i_frame_start in SCAN or DECIDE: ignored, o_overrun pulses next cycle, and the scan in progress is unaffected.
- i_frame_start in the cycle the FSM enters IDLE from DECIDE is still an overrun. Acceptance starts the cycle after.
- Arithmetic: all compares are unsigned. The address counter stops at NBIN-1 with no wrap.

Decomposition:
- Package fft_ctrl_pkg: the state enum (IDLE, SCAN, DECIDE), width constants IDW/MAGW/CNTW, and the default THRESHOLD/L_TIME.
- One sub-module, fft_peak_tracker: running max/index with clear, sample-enable and MIN_BIN gating. The FSM, stability logic and hold timer stay in the top.

Test Plan:
Use NBIN=16, MIN_BIN=1, THRESHOLD=8, STABLE=2, L_TIME=100 unless stated.
1. Reset: assert rst=0 mid-SCAN (bin 7) -> all outputs 0 immediately, o_rd_en=0. After release, the next start scans 0..15 normally.
2. Two frames with bin 5=20 and others 3, starts 40 cycles apart -> no o_valid after frame 1. o_valid=1 for 1 cycle at start2+19, o_max_id=5, o_max_magn=20.
3. Tie and DC: bin 0=31, bins 3 and 9 both 12, two frames -> o_max_id=3 emitted. Bin 0 is never selected.
4. Threshold boundary: peak exactly 8 for 3 frames -> no o_valid. Peak 9 for 2 frames -> o_valid.
5. Hold: frames of peak bin 4=15 every 20 cycles -> o_valid on frame 2, suppressed until 100 cycles elapse, then re-emits on the first frame after that.
6. Overrun: i_frame_start pulsed at start+5 and in the DECIDE cycle -> o_overrun pulses twice, scan addresses unchanged, exactly one decision.
